// File: rtl/clock_pkg.sv
// Shared clocking constants: phase width, DRAM DCM phase window and
// the phase-shift controller state encoding.
package clock_pkg;

   localparam int PHASE_W        = 9;
   localparam int DRAM_PHASE_MIN = -255;
   localparam int DRAM_PHASE_MAX = 255;
   localparam int PS_TIMEOUT     = 1023;

   localparam logic [1:0] ENC_UNLOCKED = 2'd0;
   localparam logic [1:0] ENC_IDLE     = 2'd1;
   localparam logic [1:0] ENC_STEP     = 2'd2;
   localparam logic [1:0] ENC_WAIT     = 2'd3;

   typedef enum logic [1:0] {
      S_UNLOCKED = ENC_UNLOCKED,
      S_IDLE     = ENC_IDLE,
      S_STEP     = ENC_STEP,
      S_WAIT     = ENC_WAIT
   } state_t;

endpackage

// File: rtl/ps_timeout_counter.sv
// Saturating cycle counter bounding the wait for PSDONE after one PSEN pulse.
module ps_timeout_counter #(
   parameter int TIMEOUT = 1023
) (
   input  logic clk_48,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int               CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk_48) begin
      if (rst || clear) begin
         count_reg <= '0;
      end else if (enable && (count_reg != CNT_MAX)) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign expired = (count_reg == CNT_MAX);

endmodule

// File: rtl/dcm_phase_ctrl.sv
// Walks a DCM_SP variable phase shift toward a clamped signed target,
// one PSEN step at a time, tracking the applied offset.
module dcm_phase_ctrl #(
   parameter int PHASE_W   = clock_pkg::PHASE_W,
   parameter int PHASE_MIN = clock_pkg::DRAM_PHASE_MIN,
   parameter int PHASE_MAX = clock_pkg::DRAM_PHASE_MAX,
   parameter int TIMEOUT   = clock_pkg::PS_TIMEOUT
) (
   input  logic                      clk_48,
   input  logic                      rst,
   input  logic                      dcm_locked,
   input  logic                      dcm_ps_ovf,
   input  logic signed [PHASE_W-1:0] target,
   input  logic                      target_valid,
   output logic                      target_ready,
   output logic                      psen,
   output logic                      psincdec,
   input  logic                      psdone,
   output logic signed [PHASE_W-1:0] phase,
   output logic                      busy,
   output logic                      done,
   output logic                      error
);

   import clock_pkg::*;

   localparam logic signed [PHASE_W-1:0] MIN_V = PHASE_W'(PHASE_MIN);
   localparam logic signed [PHASE_W-1:0] MAX_V = PHASE_W'(PHASE_MAX);
   localparam logic signed [PHASE_W-1:0] ONE   = PHASE_W'(1);

   state_t                    state_reg, state_next;
   logic signed [PHASE_W-1:0] phase_reg, phase_next;
   logic signed [PHASE_W-1:0] goal_reg, goal_next;
   logic signed [PHASE_W-1:0] clamped, stepped;
   logic                      psincdec_reg, psincdec_next;
   logic                      psen_reg, psen_next;
   logic                      done_reg, done_next;
   logic                      error_reg, error_next;
   logic                      ready_reg, ready_next;
   logic                      accept, cnt_clear, cnt_en, cnt_expired;

   ps_timeout_counter #(
      .TIMEOUT(TIMEOUT)
   ) u_timeout (
      .clk_48 (clk_48),
      .rst    (rst),
      .clear  (cnt_clear),
      .enable (cnt_en),
      .expired(cnt_expired)
   );

   always_comb begin
      if (target < MIN_V) begin
         clamped = MIN_V;
      end else if (target > MAX_V) begin
         clamped = MAX_V;
      end else begin
         clamped = target;
      end
   end

   assign stepped = psincdec_reg ? (phase_reg + ONE) : (phase_reg - ONE);
   assign accept  = (state_reg == S_IDLE) && target_valid && ready_reg && dcm_locked;

   always_comb begin
      state_next    = state_reg;
      phase_next    = phase_reg;
      goal_next     = goal_reg;
      psincdec_next = psincdec_reg;
      done_next     = 1'b0;
      error_next    = error_reg;
      cnt_clear     = 1'b0;
      cnt_en        = 1'b0;

      case (state_reg)
         S_UNLOCKED: begin
            // A DCM reset restores zero offset, so the tracked phase follows.
            phase_next = '0;
            if (dcm_locked) begin
               state_next = S_IDLE;
            end
         end
         S_IDLE: begin
            if (accept) begin
               goal_next  = clamped;
               error_next = 1'b0;
               if (clamped == phase_reg) begin
                  done_next = 1'b1;
               end else begin
                  state_next    = S_STEP;
                  psincdec_next = (clamped > phase_reg);
               end
            end
         end
         S_STEP: begin
            cnt_clear  = 1'b1;
            state_next = S_WAIT;
         end
         S_WAIT: begin
            cnt_en = 1'b1;
            if (psdone) begin
               if (dcm_ps_ovf) begin
                  error_next = 1'b1;
                  state_next = S_IDLE;
               end else begin
                  phase_next = stepped;
                  if (stepped == goal_reg) begin
                     done_next  = 1'b1;
                     state_next = S_IDLE;
                  end else begin
                     state_next = S_STEP;
                  end
               end
            end else if (cnt_expired) begin
               // Offset is unknown now; upstream must reset the DCM.
               error_next = 1'b1;
               phase_next = '0;
               state_next = S_UNLOCKED;
            end
         end
         default: begin
            state_next = S_UNLOCKED;
         end
      endcase

      if (!dcm_locked) begin
         state_next = S_UNLOCKED;
         phase_next = '0;
         done_next  = 1'b0;
         error_next = error_reg;
      end

      psen_next  = (state_next == S_STEP);
      ready_next = (state_next == S_IDLE) && !accept;
   end

   always_ff @(posedge clk_48) begin
      if (rst) begin
         state_reg    <= S_UNLOCKED;
         phase_reg    <= '0;
         goal_reg     <= '0;
         psincdec_reg <= 1'b0;
         psen_reg     <= 1'b0;
         done_reg     <= 1'b0;
         error_reg    <= 1'b0;
         ready_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         phase_reg    <= phase_next;
         goal_reg     <= goal_next;
         psincdec_reg <= psincdec_next;
         psen_reg     <= psen_next;
         done_reg     <= done_next;
         error_reg    <= error_next;
         ready_reg    <= ready_next;
      end
   end

   assign target_ready = ready_reg;
   assign psen         = psen_reg;
   assign psincdec     = psincdec_reg;
   assign phase        = phase_reg;
   assign busy         = (state_reg == S_STEP) || (state_reg == S_WAIT);
   assign done         = done_reg;
   assign error        = error_reg;

endmodule

// File: tb/tb_dcm_phase_ctrl.sv
// Self-checking bench for dcm_phase_ctrl with a behavioural DCM phase-shift model.
module tb_dcm_phase_ctrl;

   logic              clk_48 = 1'b0;
   logic              rst = 1'b1;
   logic              dcm_locked = 1'b0;
   logic              dcm_ps_ovf = 1'b0;
   logic signed [8:0] target = '0;
   logic              target_valid = 1'b0;
   logic              target_ready;
   logic              psen;
   logic              psincdec;
   logic              psdone = 1'b0;
   logic signed [8:0] phase;
   logic              busy;
   logic              done;
   logic              error;

   dcm_phase_ctrl dut (
      .clk_48      (clk_48),
      .rst         (rst),
      .dcm_locked  (dcm_locked),
      .dcm_ps_ovf  (dcm_ps_ovf),
      .target      (target),
      .target_valid(target_valid),
      .target_ready(target_ready),
      .psen        (psen),
      .psincdec    (psincdec),
      .psdone      (psdone),
      .phase       (phase),
      .busy        (busy),
      .done        (done),
      .error       (error)
   );

   always #5 clk_48 = ~clk_48;

   int checks = 0;
   int failures = 0;

   // reference model state
   int exp_phase = 0;
   int exp_goal = 0;
   bit exp_dir = 1'b0;

   // DCM model controls
   int lat = 5;
   bit suppress = 1'b0;
   int ovf_at = 0;
   int psdone_total = 0;

   // monitor totals
   int   psen_total = 0, dir_err_total = 0, wide_total = 0;
   int   done_total = 0, done_phase_err_total = 0, busy_total = 0;
   logic psen_prev = 1'b0;
   int   last_phase = 0;
   int   hist[$];

   // snapshots
   int b_psen, b_dir, b_wide, b_done, b_dpe, b_busy, b_hist;

   function automatic int clamp(input int t);
      if (t < -255) return -255;
      if (t > 255) return 255;
      return t;
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // DCM: PSDONE arrives lat edges after the PSEN cycle
   always begin
      @(negedge clk_48);
      if (psen === 1'b1 && !suppress) begin
         repeat (lat) @(posedge clk_48);
         #1;
         psdone_total = psdone_total + 1;
         psdone = 1'b1;
         if (psdone_total == ovf_at) dcm_ps_ovf = 1'b1;
         @(posedge clk_48);
         #1;
         psdone = 1'b0;
         dcm_ps_ovf = 1'b0;
      end
   end

   always @(negedge clk_48) begin
      if (psen === 1'b1) begin
         psen_total = psen_total + 1;
         if (psincdec !== exp_dir) dir_err_total = dir_err_total + 1;
         if (psen_prev === 1'b1) wide_total = wide_total + 1;
      end
      psen_prev = psen;
      if (done === 1'b1) begin
         done_total = done_total + 1;
         if (int'(phase) != exp_goal) done_phase_err_total = done_phase_err_total + 1;
      end
      if (busy === 1'b1) busy_total = busy_total + 1;
      if (int'(phase) != last_phase) begin
         hist.push_back(int'(phase));
         last_phase = int'(phase);
      end
   end

   task automatic tick();
      @(negedge clk_48);
      #1;
   endtask

   task automatic snap();
      b_psen = psen_total;
      b_dir  = dir_err_total;
      b_wide = wide_total;
      b_done = done_total;
      b_dpe  = done_phase_err_total;
      b_busy = busy_total;
      b_hist = hist.size();
   endtask

   // Waits for ready, presents one request; returns in the cycle after acceptance.
   task automatic send(input int t);
      int n = 0;
      while (target_ready !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      if (target_ready !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL ready_wait: target_ready=%b required 1", target_ready);
      end
      snap();
      exp_goal = clamp(t);
      exp_dir  = (exp_goal > exp_phase);
      $display("req target=%0d goal=%0d from=%0d lat=%0d", t, exp_goal, exp_phase, lat);
      target = 9'(t);
      target_valid = 1'b1;
      tick();
      target_valid = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (busy === 1'b1 && n < bound) begin
         tick();
         n++;
      end
      if (busy === 1'b1) begin
         checks++;
         failures++;
         $display("FAIL busy_wait: busy still 1 after %0d cycles", bound);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      dcm_locked = 1'b0;
      repeat (3) tick();
      checks++; if (phase !== 9'sd0) begin failures++; $display("FAIL rst_phase: got %0d required 0", phase); end
      checks++; if (psen !== 1'b0) begin failures++; $display("FAIL rst_psen: got %b required 0", psen); end
      checks++; if (psincdec !== 1'b0) begin failures++; $display("FAIL rst_psincdec: got %b required 0", psincdec); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b required 0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b required 0", done); end
      checks++; if (error !== 1'b0) begin failures++; $display("FAIL rst_error: got %b required 0", error); end
      checks++; if (target_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b required 0", target_ready); end
      rst = 1'b0;
      repeat (3) tick();
      checks++; if (target_ready !== 1'b0) begin failures++; $display("FAIL unlocked_ready: got %b required 0", target_ready); end
      dcm_locked = 1'b1;
      repeat (3) tick();
      checks++; if (target_ready !== 1'b1) begin failures++; $display("FAIL locked_ready: got %b required 1", target_ready); end
      exp_phase = 0;
   endtask

   task automatic test_basic_step();
      bit seq_ok;
      lat = 5;
      send(3);
      wait_idle(200);
      tick();
      checks++; if (psen_total - b_psen != 3) begin failures++; $display("FAIL basic_pulses: got %0d required 3", psen_total - b_psen); end
      checks++; if (dir_err_total != b_dir) begin failures++; $display("FAIL basic_dir: %0d pulses with psincdec!=1", dir_err_total - b_dir); end
      checks++; if (wide_total != b_wide) begin failures++; $display("FAIL basic_psen_width: %0d multi-cycle pulses required 0", wide_total - b_wide); end
      seq_ok = (hist.size() - b_hist == 3);
      if (seq_ok) seq_ok = (hist[b_hist] == 1) && (hist[b_hist+1] == 2) && (hist[b_hist+2] == 3);
      checks++; if (!seq_ok) begin failures++; $display("FAIL basic_sequence: %0d phase changes, required 1,2,3", hist.size() - b_hist); end
      checks++; if (done_total - b_done != 1) begin failures++; $display("FAIL basic_done: got %0d pulses required 1", done_total - b_done); end
      checks++; if (done_phase_err_total != b_dpe) begin failures++; $display("FAIL basic_done_phase: done before phase reached goal"); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy: got %b required 0", busy); end
      exp_phase = exp_goal;
   endtask

   task automatic test_clamp_decrement();
      int need;
      lat = 1;
      // -256 is the one 9-bit request outside the legal window
      send(-256);
      need = iabs(exp_goal - exp_phase);
      wait_idle(4000);
      tick();
      checks++; if (psen_total - b_psen != need) begin failures++; $display("FAIL clamp_pulses: got %0d required %0d", psen_total - b_psen, need); end
      checks++; if (dir_err_total != b_dir) begin failures++; $display("FAIL clamp_dir: %0d pulses with psincdec!=0", dir_err_total - b_dir); end
      checks++; if (int'(phase) != -255) begin failures++; $display("FAIL clamp_phase: got %0d required -255", phase); end
      checks++; if (done_total - b_done != 1) begin failures++; $display("FAIL clamp_done: got %0d pulses required 1", done_total - b_done); end
      exp_phase = exp_goal;
   endtask

   task automatic test_zero_move();
      send(exp_phase);
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done_timing: got %b required 1", done); end
      checks++; if (target_ready !== 1'b0) begin failures++; $display("FAIL zero_ready_after_accept: got %b required 0", target_ready); end
      repeat (4) tick();
      checks++; if (psen_total != b_psen) begin failures++; $display("FAIL zero_psen: got %0d pulses required 0", psen_total - b_psen); end
      checks++; if (done_total - b_done != 1) begin failures++; $display("FAIL zero_done_count: got %0d required 1", done_total - b_done); end
   endtask

   task automatic test_random();
      int t, need;
      for (int i = 0; i < 6; i++) begin
         t = exp_phase + int'($urandom_range(0, 60)) - 30;
         if (t < -256) t = -256;
         if (t > 255) t = 255;
         lat = int'($urandom_range(1, 6));
         send(t);
         need = iabs(exp_goal - exp_phase);
         wait_idle(need * 12 + 50);
         tick();
         checks++; if (psen_total - b_psen != need) begin failures++; $display("FAIL rand_pulses[%0d]: got %0d required %0d", i, psen_total - b_psen, need); end
         checks++; if (dir_err_total != b_dir) begin failures++; $display("FAIL rand_dir[%0d]: %0d wrong-direction pulses", i, dir_err_total - b_dir); end
         checks++; if (int'(phase) != exp_goal) begin failures++; $display("FAIL rand_phase[%0d]: got %0d required %0d", i, phase, exp_goal); end
         checks++; if (done_total - b_done != 1 || done_phase_err_total != b_dpe) begin failures++; $display("FAIL rand_done[%0d]: got %0d pulses (%0d early) required 1", i, done_total - b_done, done_phase_err_total - b_dpe); end
         exp_phase = exp_goal;
      end
   endtask

   task automatic test_overflow();
      lat = 2;
      send(0);
      wait_idle(3000);
      tick();
      exp_phase = exp_goal;
      ovf_at = psdone_total + 2;
      send(5);
      wait_idle(200);
      tick();
      ovf_at = 0;
      checks++; if (error !== 1'b1) begin failures++; $display("FAIL ovf_error: got %b required 1", error); end
      checks++; if (int'(phase) != 1) begin failures++; $display("FAIL ovf_phase: got %0d required 1", phase); end
      checks++; if (done_total != b_done) begin failures++; $display("FAIL ovf_done: got %0d pulses required 0", done_total - b_done); end
      checks++; if (psen_total - b_psen != 2) begin failures++; $display("FAIL ovf_pulses: got %0d required 2", psen_total - b_psen); end
      checks++; if (target_ready !== 1'b1) begin failures++; $display("FAIL ovf_idle: target_ready=%b required 1", target_ready); end
      exp_phase = 1;
      send(1);
      checks++; if (error !== 1'b0) begin failures++; $display("FAIL ovf_error_clear: got %b required 0", error); end
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL ovf_next_done: got %b required 1", done); end
   endtask

   task automatic test_timeout();
      int bc;
      suppress = 1'b1;
      send(exp_phase + 3);
      wait_idle(1200);
      bc = busy_total - b_busy;
      checks++; if (error !== 1'b1) begin failures++; $display("FAIL tmo_error: got %b required 1", error); end
      checks++; if (phase !== 9'sd0) begin failures++; $display("FAIL tmo_phase: got %0d required 0", phase); end
      checks++; if (target_ready !== 1'b0) begin failures++; $display("FAIL tmo_unlocked: target_ready=%b required 0", target_ready); end
      checks++; if (bc < 1024 || bc > 1026) begin failures++; $display("FAIL tmo_cycles: busy for %0d cycles required ~1025", bc); end
      checks++; if (done_total != b_done) begin failures++; $display("FAIL tmo_done: got %0d pulses required 0", done_total - b_done); end
      suppress = 1'b0;
      exp_phase = 0;
      repeat (3) tick();
      checks++; if (target_ready !== 1'b1) begin failures++; $display("FAIL tmo_relock_ready: got %b required 1", target_ready); end
   endtask

   task automatic test_lock_loss();
      int n = 0;
      int bad_r = 0, bad_p = 0, bad_ph = 0, bad_b = 0;
      lat = 3;
      send(10);
      while (psen_total - b_psen < 3 && n < 200) begin
         tick();
         n++;
      end
      checks++; if (psen_total - b_psen < 3) begin failures++; $display("FAIL lock_walk: got %0d pulses required 3", psen_total - b_psen); end
      dcm_locked = 1'b0;
      snap();
      for (int i = 0; i < 20; i++) begin
         tick();
         if (target_ready !== 1'b0) bad_r++;
         if (psen !== 1'b0) bad_p++;
         if (phase !== 9'sd0) bad_ph++;
         if (busy !== 1'b0) bad_b++;
      end
      checks++; if (bad_r != 0) begin failures++; $display("FAIL lock_ready: high in %0d cycles required 0", bad_r); end
      checks++; if (bad_p != 0) begin failures++; $display("FAIL lock_psen: high in %0d cycles required 0", bad_p); end
      checks++; if (bad_ph != 0) begin failures++; $display("FAIL lock_phase: nonzero in %0d cycles required 0", bad_ph); end
      checks++; if (bad_b != 0) begin failures++; $display("FAIL lock_busy: high in %0d cycles required 0", bad_b); end
      checks++; if (done_total != b_done) begin failures++; $display("FAIL lock_done: got %0d pulses required 0", done_total - b_done); end
      dcm_locked = 1'b1;
      exp_phase = 0;
      repeat (3) tick();
      checks++; if (target_ready !== 1'b1 || phase !== 9'sd0) begin failures++; $display("FAIL lock_return: ready=%b phase=%0d required 1/0", target_ready, phase); end
   endtask

   task automatic test_reset_in_wait();
      lat = 8;
      send(exp_phase + 5);
      tick();
      checks++; if (busy !== 1'b1 || psen !== 1'b0) begin failures++; $display("FAIL rw_in_wait: busy=%b psen=%b required 1/0", busy, psen); end
      rst = 1'b1;
      tick();
      checks++; if (phase !== 9'sd0) begin failures++; $display("FAIL rw_phase: got %0d required 0", phase); end
      checks++; if (psincdec !== 1'b0) begin failures++; $display("FAIL rw_psincdec: got %b required 0", psincdec); end
      checks++; if (busy !== 1'b0 || psen !== 1'b0) begin failures++; $display("FAIL rw_busy_psen: busy=%b psen=%b required 0/0", busy, psen); end
      checks++; if (done !== 1'b0 || error !== 1'b0) begin failures++; $display("FAIL rw_done_error: done=%b error=%b required 0/0", done, error); end
      checks++; if (target_ready !== 1'b0) begin failures++; $display("FAIL rw_ready: got %b required 0", target_ready); end
      rst = 1'b0;
      exp_phase = 0;
      repeat (12) tick();
   endtask

   initial begin
      test_reset();
      test_basic_step();
      test_clamp_decrement();
      test_zero_move();
      test_random();
      test_overflow();
      test_timeout();
      test_lock_loss();
      test_reset_in_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
